regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources:
//  A = ALU result, B = load unit.
//  Round-robin arbitration with a valid/ready handshake per source.
//  The granted request is registered into one output stage that drives
//  register_file.wr_en / wr_reg / wr_data.
//  Sits between the execute/memory writeback logic and register_file.
// PARAMETERS
//  DATA_WIDTH  32  width of write data
//  ADDR_WIDTH  5   register index width (32 registers, x0 hardwired zero)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  hold       in   1           pipeline freeze; no grants while high
//  a_valid    in   1           source A request
//  a_ready    out  1           source A accepted this cycle (comb.)
//  a_reg      in   ADDR_WIDTH  source A destination register
//  a_data     in   DATA_WIDTH  source A write data
//  b_valid    in   1           source B request
//  b_ready    out  1           source B accepted this cycle (comb.)
//  b_reg      in   ADDR_WIDTH  source B destination register
//  b_data     in   DATA_WIDTH  source B write data
//  wr_en      out  1           to register_file.wr_en (registered)
//  wr_reg     out  ADDR_WIDTH  to register_file.wr_reg (registered)
//  wr_data    out  DATA_WIDTH  to register_file.wr_data (registered)
//  rd_reg_1   in   ADDR_WIDTH  [REGFILE_ARB_FWD_EN] read index, port 1
//  rd_reg_2   in   ADDR_WIDTH  [REGFILE_ARB_FWD_EN] read index, port 2
//  fwd_hit_1  out  1           [REGFILE_ARB_FWD_EN] port 1 matches in-flight write
//  fwd_hit_2  out  1           [REGFILE_ARB_FWD_EN] port 2 matches in-flight write
//  fwd_data   out  DATA_WIDTH  [REGFILE_ARB_FWD_EN] in-flight data (= wr_data)
// BEHAVIOUR
//  - Reset: wr_en=0, wr_reg=0, wr_data=0, priority state = PRI_A.
//    a_ready/b_ready are 0 while rst_n=0.
//  - Priority FSM has two states: PRI_A, PRI_B.
//    - Only one source valid: that source is granted.
//    - Both valid: the source named by the state is granted.
//    - After any grant, state moves to favour the other source
//      (grant A -> PRI_B, grant B -> PRI_A). No grant -> state unchanged.
//  - Handshake:
//    - x_ready = x_valid & grant_x & ~hold & rst_n.
//    - Transfer occurs on the clk edge where x_valid & x_ready.
//    - Exactly one of a_ready/b_ready is high at most per cycle.
//    - Ungranted source holds valid/reg/data stable until ready.
//  - Latency: transfer at edge N -> wr_en=1 with that reg/data during cycle N+1;
//    register_file commits at edge N+1. One write per cycle sustained.
//  - No transfer at edge N: wr_en=0 in cycle N+1. wr_reg/wr_data keep their
//    previous values.
//  - x0 destination: the request is accepted (ready asserted, FSM advances) but
//    wr_en stays 0 for that slot. The write is dropped here, not in the file.
//  - hold=1: both readys 0, FSM frozen. The output stage still drains
//    (wr_en=0 next cycle).
//  - Same register from A and B in the same cycle: serialized in RR order.
//    The later grant wins in the file.
//  - Async reset mid-operation: any in-flight output write is discarded
//    (wr_en forced 0 immediately). Transfers already acknowledged are lost;
//    requests not yet transferred remain pending at the sources.
// CONFIGURATION
//  REGFILE_ARB_FWD_EN defined:
//    - Adds rd_reg_1/2, fwd_hit_1/2, fwd_data.
//    - fwd_hit_n = wr_en & (wr_reg == rd_reg_n) & (rd_reg_n != 0), combinational.
//    - fwd_data = wr_data.
//    - Lets readers bypass the read-before-write value the file returns
//      during the commit cycle.
//  REGFILE_ARB_FWD_EN undefined:
//    - Those ports do not exist; no forwarding logic is built.
// TESTING
//  - Reset, then idle:
//    wr_en=0, wr_reg=0, wr_data=0, both readys 0 during reset.
//  - A only, a_reg=5, a_data=32'hDEADBEEF:
//    a_ready=1 same cycle; next cycle wr_en=1, wr_reg=5, wr_data=DEADBEEF;
//    reading x5 afterwards returns DEADBEEF.
//  - A and B valid for 4 cycles (a_reg=1, b_reg=2) from reset:
//    grants A,B,A,B; wr_reg sequence 1,2,1,2, wr_en=1 every cycle.
//  - b_reg=0, b_data=32'hFFFFFFFF:
//    b_ready=1, next cycle wr_en=0; x0 reads 0. hold=1 with both valid:
//    no readys, FSM state unchanged after release.
//  - Assert rst_n=0 mid-cycle while wr_en=1:
//    wr_en drops to 0 immediately; after release, state=PRI_A.
//  - FWD_EN: write x7=32'h12345678 with rd_reg_1=7, rd_reg_2=0 in the commit
//    cycle: fwd_hit_1=1, fwd_hit_2=0, fwd_data=12345678.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter that merges the ALU (A) and load-unit (B) writebacks into the single register-file write port.
// Optional read-port forwarding of the in-flight write is built when REGFILE_ARB_FWD_EN is defined.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_reg,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_reg,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_reg,
`ifdef REGFILE_ARB_FWD_EN
  input  logic [ADDR_WIDTH-1:0] rd_reg_1,
  input  logic [ADDR_WIDTH-1:0] rd_reg_2,
  output logic                  fwd_hit_1,
  output logic                  fwd_hit_2,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  dbg_pri_state
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e                  pri_q, pri_d;
  logic                  grant_a, grant_b;
  logic                  a_xfer, b_xfer;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // Handshake: a source transfers on the rising edge where x_valid and x_ready are
  // both high; x_ready never depends on the other source's ready, and an ungranted
  // source keeps valid/reg/data stable until it sees ready.
  assign grant_a = a_valid & (~b_valid | (pri_q == PRI_A));
  assign grant_b = b_valid & ~grant_a;
  assign a_xfer  = a_valid & a_ready;
  assign b_xfer  = b_valid & b_ready;

  // Priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_A;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Next-state: the winner hands priority to the other source
  always_comb begin
    pri_d = pri_q;
    if (a_xfer) begin
      pri_d = PRI_B;
    end else if (b_xfer) begin
      pri_d = PRI_A;
    end
  end

  // Outputs of the FSM: readys gated by freeze and by reset itself
  always_comb begin
    a_ready       = grant_a & ~hold & rst_n;
    b_ready       = grant_b & ~hold & rst_n;
    dbg_pri_state = pri_q;
  end

  // Writes to x0 are accepted but never reach the file; reg/data only move on a real write.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (a_xfer && (a_reg != '0)) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = a_reg;
      wr_data_d = a_data;
    end else if (b_xfer && (b_reg != '0)) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = b_reg;
      wr_data_d = b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

`ifdef REGFILE_ARB_FWD_EN
  // Bypass for readers that would otherwise see the pre-commit value this cycle
  assign fwd_hit_1 = wr_en_q & (wr_reg_q == rd_reg_1) & (rd_reg_1 != '0);
  assign fwd_hit_2 = wr_en_q & (wr_reg_q == rd_reg_2) & (rd_reg_2 != '0);
  assign fwd_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus randomized traffic
// compared against a turn-taking reference model and a shadow register file.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        dbg_pri_state;
`ifdef REGFILE_ARB_FWD_EN
  logic [4:0]  rd_reg_1, rd_reg_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data;
`endif

  int errors;
  int checks;

  // Reference model: who wins a tie next, the expected output slot, and the file contents.
  logic        exp_turn_b;
  logic        exp_wr_en;
  logic [4:0]  exp_wr_reg;
  logic [31:0] exp_wr_data;
  logic        vals_known;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32] = '{default: 32'h0};

  regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_reg         (a_reg),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_reg         (b_reg),
    .b_data        (b_data),
    .wr_en         (wr_en),
    .wr_reg        (wr_reg),
`ifdef REGFILE_ARB_FWD_EN
    .rd_reg_1      (rd_reg_1),
    .rd_reg_2      (rd_reg_2),
    .fwd_hit_1     (fwd_hit_1),
    .fwd_hit_2     (fwd_hit_2),
    .fwd_data      (fwd_data),
`endif
    .wr_data       (wr_data),
    .dbg_pri_state (dbg_pri_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shadow of the register file fed by the DUT write port (x0 hardwired zero)
  always @(posedge clk) begin
    if (wr_en && (wr_reg != 5'd0)) dut_rf[wr_reg] <= wr_data;
  end

  task automatic model_reset();
    exp_turn_b  = 1'b0;
    exp_wr_en   = 1'b0;
    exp_wr_reg  = 5'd0;
    exp_wr_data = 32'h0;
    vals_known  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive at negedge, check against the model, advance model across the edge.
  task automatic step(input string name,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd,
                      input logic h, output logic a_acc, output logic b_acc);
    logic ea, eb;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    hold = h;
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (!h && av && (!bv || !exp_turn_b)) ea = 1'b1;
    else if (!h && bv) eb = 1'b1;
    checks++;
    if (a_ready !== ea) begin
      errors++; $display("FAIL %s a_ready: got %b expected %b", name, a_ready, ea);
    end
    checks++;
    if (b_ready !== eb) begin
      errors++; $display("FAIL %s b_ready: got %b expected %b", name, b_ready, eb);
    end
    checks++;
    if (wr_en !== exp_wr_en) begin
      errors++; $display("FAIL %s wr_en: got %b expected %b", name, wr_en, exp_wr_en);
    end
    checks++;
    if (dbg_pri_state !== exp_turn_b) begin
      errors++; $display("FAIL %s pri_state: got %b expected %b", name, dbg_pri_state, exp_turn_b);
    end
    if (vals_known) begin
      checks++;
      if (wr_reg !== exp_wr_reg || wr_data !== exp_wr_data) begin
        errors++;
        $display("FAIL %s wr_reg/wr_data: got %0d/%h expected %0d/%h",
                 name, wr_reg, wr_data, exp_wr_reg, exp_wr_data);
      end
    end
    a_acc = ea;
    b_acc = eb;
    if (exp_wr_en) exp_rf[exp_wr_reg] = exp_wr_data;
    exp_wr_en = 1'b0;
    if (ea || eb) begin
      if ((ea ? ar : br) != 5'd0) begin
        exp_wr_en   = 1'b1;
        exp_wr_reg  = ea ? ar : br;
        exp_wr_data = ea ? ad : bd;
        vals_known  = 1'b1;
      end else begin
        vals_known = 1'b0;
      end
      exp_turn_b = ea;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold = 1'b0;
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h1;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h2;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL reset readys: got %b%b expected 00", a_ready, b_ready);
    end
    checks++;
    if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'h0) begin
      errors++; $display("FAIL reset outputs: got %b/%0d/%h expected 0/0/0", wr_en, wr_reg, wr_data);
    end
    checks++;
    if (dbg_pri_state !== 1'b0) begin
      errors++; $display("FAIL reset pri_state: got %b expected 0", dbg_pri_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_a_only();
    logic aa, ba;
    step("a_only_req", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, aa, ba);
    step("a_only_wr", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
    step("a_only_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
    checks++;
    if (dut_rf[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL a_only x5: got %h expected deadbeef", dut_rf[5]);
    end
  endtask

  task automatic test_alternate();
    logic aa, ba;
    logic [3:0] a_seen;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step("alternate", 1, 5'd1, 32'hA0 + i, 1, 5'd2, 32'hB0 + i, 0, aa, ba);
      a_seen[i] = aa;
    end
    step("alternate_tail", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
    checks++;
    if (a_seen !== 4'b0101) begin
      errors++; $display("FAIL alternate order: got %b expected 0101", a_seen);
    end
    step("alternate_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
  endtask

  task automatic test_x0_and_hold();
    logic aa, ba;
    step("x0_req", 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, 0, aa, ba);
    step("x0_drop", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
    checks++;
    if (dut_rf[0] !== 32'h0) begin
      errors++; $display("FAIL x0 read: got %h expected 00000000", dut_rf[0]);
    end
    step("pre_hold", 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, aa, ba);
    for (int i = 0; i < 3; i++)
      step("hold", 1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 1, aa, ba);
    step("hold_release", 1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 0, aa, ba);
    step("hold_release2", 1, 5'd8, 32'h88, 0, 5'd0, 32'h0, 0, aa, ba);
    step("hold_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
  endtask

  task automatic test_async_reset();
    logic aa, ba;
    step("async_req", 1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 32'h0, 0, aa, ba);
    #2;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++; $display("FAIL async pre wr_en: got %b expected 1", wr_en);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL async reset: got wr_en=%b readys=%b%b expected 0 00", wr_en, a_ready, b_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dbg_pri_state !== 1'b0) begin
      errors++; $display("FAIL async release pri_state: got %b expected 0", dbg_pri_state);
    end
    step("async_after", 1, 5'd10, 32'h1010, 1, 5'd11, 32'h1111, 0, aa, ba);
    step("async_after2", 0, 5'd0, 32'h0, 1, 5'd11, 32'h1111, 0, aa, ba);
    step("async_idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
  endtask

  task automatic test_random();
    logic aa, ba, ap, bp, h;
    logic [4:0] ar, br;
    logic [31:0] ad, bd;
    ap = 0; bp = 0; ar = 0; br = 0; ad = 0; bd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ap && $urandom_range(0, 99) < 60) begin
        ap = 1; ar = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!bp && $urandom_range(0, 99) < 60) begin
        bp = 1; br = 5'($urandom_range(0, 31)); bd = $urandom;
      end
      h = ($urandom_range(0, 9) == 0);
      step("random", ap, ar, ad, bp, br, bd, h, aa, ba);
      if (aa) ap = 0;
      if (ba) bp = 0;
    end
    step("random_drain", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
    step("random_drain2", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, aa, ba);
  endtask

`ifdef REGFILE_ARB_FWD_EN
  task automatic test_fwd();
    logic aa, ba;
    rd_reg_1 = 5'd0; rd_reg_2 = 5'd0;
    step("fwd_req", 1, 5'd7, 32'h12345678, 0, 5'd0, 32'h0, 0, aa, ba);
    rd_reg_1 = 5'd7; rd_reg_2 = 5'd0;
    #1;
    checks++;
    if (fwd_hit_1 !== 1'b1 || fwd_hit_2 !== 1'b0 || fwd_data !== 32'h12345678) begin
      errors++; $display("FAIL fwd port1: got %b%b/%h expected 10/12345678", fwd_hit_1, fwd_hit_2, fwd_data);
    end
    rd_reg_1 = 5'd3; rd_reg_2 = 5'd7;
    #1;
    checks++;
    if (fwd_hit_1 !== 1'b0 || fwd_hit_2 !== 1'b1) begin
      errors++; $display("FAIL fwd port2: got %b%b expected 01", fwd_hit_1, fwd_hit_2);
    end
    @(negedge clk);
    if (exp_wr_en) exp_rf[exp_wr_reg] = exp_wr_data;
    exp_wr_en = 1'b0;
    #1;
    checks++;
    if (fwd_hit_2 !== 1'b0) begin
      errors++; $display("FAIL fwd idle: got %b expected 0", fwd_hit_2);
    end
  endtask
`endif

  task automatic test_regfile_contents();
    for (int i = 1; i < 32; i++) begin
      checks++;
      if (dut_rf[i] !== exp_rf[i]) begin
        errors++; $display("FAIL regfile x%0d: got %h expected %h", i, dut_rf[i], exp_rf[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
`ifdef REGFILE_ARB_FWD_EN
    rd_reg_1 = 5'd0;
    rd_reg_2 = 5'd0;
`endif
    test_reset();
    test_a_only();
    test_alternate();
    test_x0_and_hold();
    test_async_reset();
`ifdef REGFILE_ARB_FWD_EN
    test_fwd();
`endif
    test_random();
    test_regfile_contents();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
